dma_bus_arbiter: RTL

Shares the single system-bus master port among the CPU instruction master, the CPU data master and the DMA master FSM. Arbitration happens only on transaction boundaries, using a round-robin scheme. A requester may raise lock to keep the bus for several consecutive transactions (DMA bursts), up to a bounded count. The block sits between the three masters and the bus mux, and drives the mux select plus one-hot grants.

---
 rtl/dma_arb_pkg.sv | 12 +
 rtl/dma_bus_arbiter_rr_picker.sv | 35 +++
 rtl/dma_bus_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA system-bus arbiter.
package dma_arb_pkg;

    typedef enum logic [0:0] {ARB, OWN} arb_state_t;

    localparam int unsigned REQ_IM           = 0;
    localparam int unsigned REQ_DM           = 1;
    localparam int unsigned REQ_DMA          = 2;
    localparam int unsigned N_REQ_DEFAULT    = REQ_DMA + 1;
    localparam int unsigned LOCK_MAX_DEFAULT = 4;

endpackage

// File: rtl/dma_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request scanning from ptr upward, wrapping at N.
module rr_picker #(
    parameter int unsigned N   = 3,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    // Low half holds only bits at or above ptr, high half the full vector,
    // so a plain lowest-bit search yields the wrapped round-robin winner.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (IDW'(i) >= ptr);
        end
        dbl = {req, req & mask};
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(2 * N); i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = IDW'(i % int'(N));
            end
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin bus arbiter for CPU IM, CPU DM and DMA; arbitrates only at
// transaction boundaries and supports bounded locked bursts.
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEFAULT,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT,
    parameter int unsigned IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic             txn_done,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic [7:0]       lock_cnt
);

    localparam logic [7:0]     LOCK_LAST = 8'(LOCK_MAX - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]       lock_cnt_q, lock_cnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic             keep_bus;
    logic [IDW-1:0]   next_ptr;

    rr_picker #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            grant_q    <= '0;
            grant_id_q <= '0;
            lock_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            lock_cnt_q <= lock_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign keep_bus = lock[grant_id_q] & req[grant_id_q] & (lock_cnt_q < LOCK_LAST);
    assign next_ptr = (grant_id_q == ID_LAST) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (pick_found) begin
                    state_d           = OWN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    grant_id_d        = pick_idx;
                    lock_cnt_d        = '0;
                end
            end
            OWN: begin
                // req/lock only matter on the closing handshake of a transaction.
                if (txn_done) begin
                    if (keep_bus) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        state_d    = ARB;
                        grant_d    = '0;
                        grant_id_d = '0;
                        lock_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_comb begin
        grant    = grant_q;
        grant_id = grant_id_q;
        busy     = (state_q == OWN);
        lock_cnt = lock_cnt_q;
    end

endmodule
